// File: rtl/z80_blockop_if.sv
// Memory handshake bundle between the block-op sequencer (master) and the memory side (slave).
interface z80_blockop_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/z80_blockop.sv
// Sequencer for Z80 LDI/LDD/LDIR/LDDR and CPI/CPD/CPIR/CPDR: memory handshake,
// BC/DE/HL stepping, repeat loop and flag formation.
module z80_blockop (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [7:0]    a,
  input  logic [7:0]    f_in,
  input  logic [15:0]   bc_in,
  input  logic [15:0]   de_in,
  input  logic [15:0]   hl_in,
  input  logic          irq_pending,
  z80_blockop_if.master mem,
  output logic [7:0]    alu_op1,
  input  logic [5:0]    ldi_xy,
  output logic [15:0]   bc,
  output logic [15:0]   de,
  output logic [15:0]   hl,
  output logic [7:0]    f_out,
  output logic          busy,
  output logic          done,
  output logic          pc_rewind
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_UPD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] bc_q, bc_d, de_q, de_d, hl_q, hl_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  keep_q, keep_d;   // {S, Z, C} of f_in, held for the flag merge
  logic [7:0]  op1_q, op1_d;
  logic [7:0]  f_q, f_d;
  logic        done_q, done_d;
  logic        rewind_q, rewind_d;

  logic [15:0] bc_dec, de_step, hl_step;
  logic [7:0]  cp_r, cp_n, flags_ld, flags_cp;
  logic        cp_h, cp_z, pv_new, go_on;

  // Only the X/Y source bits of the ALU sum and S/Z/C of f_in take part.
  logic unused_bits;
  assign unused_bits = ^{ldi_xy[5:4], ldi_xy[2], ldi_xy[0], f_in[5:1]};

  assign bc_dec  = bc_q - 16'd1;
  assign de_step = op_q[0] ? de_q - 16'd1 : de_q + 16'd1;
  assign hl_step = op_q[0] ? hl_q - 16'd1 : hl_q + 16'd1;

  assign cp_r   = a - op1_q;
  assign cp_h   = a[3:0] < op1_q[3:0];
  assign cp_n   = cp_r - {7'd0, cp_h};
  assign cp_z   = (cp_r == 8'd0);
  assign pv_new = (bc_dec != 16'd0);

  // F layout: S Z Y H X PV N C
  assign flags_ld = {keep_q[2], keep_q[1], ldi_xy[1], 1'b0, ldi_xy[3], pv_new, 1'b0, keep_q[0]};
  assign flags_cp = {cp_r[7], cp_z, cp_n[1], cp_h, cp_n[3], pv_new, 1'b1, keep_q[0]};
  assign go_on    = op_q[1] & pv_new & (~op_q[2] | ~cp_z);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    bc_d     = bc_q;
    de_d     = de_q;
    hl_d     = hl_q;
    op_d     = op_q;
    keep_d   = keep_q;
    op1_d    = op1_q;
    f_d      = f_q;
    done_d   = 1'b0;
    rewind_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bc_d    = bc_in;
          de_d    = de_in;
          hl_d    = hl_in;
          op_d    = op;
          keep_d  = {f_in[7], f_in[6], f_in[0]};
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (mem.mem_ready) begin
          op1_d   = mem.mem_rdata;
          state_d = op_q[2] ? ST_UPD : ST_WR;
        end
      end
      ST_WR: begin
        if (mem.mem_ready) state_d = ST_UPD;
      end
      default: begin
        hl_d = hl_step;
        bc_d = bc_dec;
        if (!op_q[2]) de_d = de_step;
        f_d = op_q[2] ? flags_cp : flags_ld;
        if (go_on && !irq_pending) begin
          state_d = ST_RD;
        end else begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          rewind_d = go_on;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state_q  <= ST_IDLE;
      bc_q     <= '0;
      de_q     <= '0;
      hl_q     <= '0;
      op_q     <= '0;
      keep_q   <= '0;
      op1_q    <= '0;
      f_q      <= '0;
      done_q   <= 1'b0;
      rewind_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      de_q     <= de_d;
      hl_q     <= hl_d;
      op_q     <= op_d;
      keep_q   <= keep_d;
      op1_q    <= op1_d;
      f_q      <= f_d;
      done_q   <= done_d;
      rewind_q <= rewind_d;
    end
  end

  // Requests are decoded from the state, so they drop the cycle after mem_ready.
  assign mem.mem_rd    = (state_q == ST_RD);
  assign mem.mem_wr    = (state_q == ST_WR);
  assign mem.mem_addr  = (state_q == ST_RD) ? hl_q : (state_q == ST_WR) ? de_q : 16'h0000;
  assign mem.mem_wdata = (state_q == ST_WR) ? op1_q : 8'h00;

  assign alu_op1   = op1_q;
  assign bc        = bc_q;
  assign de        = de_q;
  assign hl        = hl_q;
  assign f_out     = f_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign pc_rewind = rewind_q;

endmodule

// File: tb/tb_z80_blockop.sv
// Scoreboard bench for z80_blockop: directed block ops, expectations queued at issue,
// checked by a monitor whenever the DUT completes a memory access or signals done.
module tb_z80_blockop;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [7:0]  f;
    logic        rewind;
  } res_t;

  logic        clock = 1'b0;
  logic        reset, start, irq_pending;
  logic [2:0]  op;
  logic [7:0]  a, f_in, alu_op1, f_out, alu_sum;
  logic [15:0] bc_in, de_in, hl_in, bc, de, hl;
  logic [5:0]  ldi_xy;
  logic        busy, done, pc_rewind;

  logic [7:0]  mem [0:65535];
  int          stall_total;
  int          stall_used = 0;
  int          checks = 0;
  int          failures = 0;

  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];
  res_t        exp_res[$];

  z80_blockop_if mem_if();

  z80_blockop dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .f_in        (f_in),
    .bc_in       (bc_in),
    .de_in       (de_in),
    .hl_in       (hl_in),
    .irq_pending (irq_pending),
    .mem         (mem_if.master),
    .alu_op1     (alu_op1),
    .ldi_xy      (ldi_xy),
    .bc          (bc),
    .de          (de),
    .hl          (hl),
    .f_out       (f_out),
    .busy        (busy),
    .done        (done),
    .pc_rewind   (pc_rewind)
  );

  always #5 clock = ~clock;

  // Environment: byte-wide memory and the ALU's A + op1 sum.
  assign mem_if.mem_rdata = mem[mem_if.mem_addr];
  assign alu_sum = a + alu_op1;
  assign ldi_xy  = alu_sum[5:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: sets mem_ready for the coming edge, then scores completed accesses and done.
  always @(negedge clock) begin
    if ((mem_if.mem_rd || mem_if.mem_wr) && stall_used < stall_total) begin
      mem_if.mem_ready = 1'b0;
      stall_used++;
    end else begin
      mem_if.mem_ready = 1'b1;
    end
    if (!reset) begin
      if (mem_if.mem_rd && mem_if.mem_wr) fail_now("rd_and_wr_together");
      if (mem_if.mem_rd && mem_if.mem_ready) begin
        if (exp_rd.size() == 0) fail_now("unexpected_read");
        else check("rd_addr", 32'(mem_if.mem_addr), 32'(exp_rd.pop_front()));
      end
      if (mem_if.mem_wr && mem_if.mem_ready) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", 32'(mem_if.mem_addr), 32'(w.addr));
          check("wr_data", 32'(mem_if.mem_wdata), 32'(w.data));
        end
      end
      if (done) begin
        if (exp_res.size() == 0) fail_now("unexpected_done");
        else begin
          res_t r;
          r = exp_res.pop_front();
          check("res_bc", 32'(bc), 32'(r.bc));
          check("res_de", 32'(de), 32'(r.de));
          check("res_hl", 32'(hl), 32'(r.hl));
          check("res_f", 32'(f_out), 32'(r.f));
          check("res_rewind", 32'(pc_rewind), 32'(r.rewind));
        end
      end
    end
  end

  task automatic launch(input logic [2:0] o, input logic [7:0] av, input logic [7:0] fv,
                        input logic [15:0] b, input logic [15:0] d, input logic [15:0] h);
    @(posedge clock); #1;
    start = 1'b1; op = o; a = av; f_in = fv; bc_in = b; de_in = d; hl_in = h;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts busy cycles from now until done; exp_busy < 0 skips the latency check.
  task automatic wait_done(input string name, input int exp_busy,
                           input logic irq_en, input logic [15:0] irq_addr);
    int  n = 0;
    bit  seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy) n++;
      if (done) begin
        seen = 1;
        break;
      end
      if (irq_en && mem_if.mem_wr && mem_if.mem_addr == irq_addr) irq_pending = 1'b1;
      @(posedge clock); #1;
    end
    if (!seen) begin
      fail_now({name, "_done_timeout"});
    end else begin
      if (exp_busy >= 0) check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
      check({name, "_busy_in_done"}, 32'(busy), 32'd0);
      @(posedge clock); #1;
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    end
    irq_pending = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_rewind"}, 32'(pc_rewind), 32'd0);
    check({name, "_rdwr"}, 32'({mem_if.mem_rd, mem_if.mem_wr}), 32'd0);
    check({name, "_addr"}, 32'(mem_if.mem_addr), 32'd0);
    check({name, "_wdata"}, 32'(mem_if.mem_wdata), 32'd0);
    check({name, "_regs"}, {bc, de}, 32'd0);
    check({name, "_hl_f_op1"}, {8'd0, hl, f_out}, 32'd0);
    check({name, "_op1"}, 32'(alu_op1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; f_in = '0;
    bc_in = '0; de_in = '0; hl_in = '0; irq_pending = 1'b0; stall_total = 0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    // LDI: 0x0A copied, a+0x0A=0x0A gives Y=1 and X=1, S/Z/C kept from 0xC1, PV=1.
    mem[16'h1000] = 8'h0A;
    exp_rd.push_back(16'h1000);
    exp_wr.push_back('{16'h2000, 8'h0A});
    exp_res.push_back('{16'h0001, 16'h2001, 16'h1001, 8'hED, 1'b0});
    launch(3'b000, 8'h00, 8'hC1, 16'h0002, 16'h2000, 16'h1000);
    wait_done("ldi", 3, 1'b0, 16'h0);

    // LDDR x3 with a start pulse while busy; last byte 0x11, a=0x05 -> sum 0x16 (Y=1, X=0).
    mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22; mem[16'h1002] = 8'h33;
    exp_rd.push_back(16'h1002); exp_rd.push_back(16'h1001); exp_rd.push_back(16'h1000);
    exp_wr.push_back('{16'h2002, 8'h33});
    exp_wr.push_back('{16'h2001, 8'h22});
    exp_wr.push_back('{16'h2000, 8'h11});
    exp_res.push_back('{16'h0000, 16'h1FFF, 16'h0FFF, 8'h61, 1'b0});
    launch(3'b011, 8'h05, 8'h41, 16'h0003, 16'h2002, 16'h1002);
    @(posedge clock); #1;
    start = 1'b1; hl_in = 16'hDEAD; bc_in = 16'h0100;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("lddr", 7, 1'b0, 16'h0);   // 9 busy cycles, 2 spent on the stray start

    // CPIR: match on 2nd byte -> Z=1, PV=1, N=1, C=1, H=0, n=0.
    mem[16'h3000] = 8'h10; mem[16'h3001] = 8'h42; mem[16'h3002] = 8'h99;
    exp_rd.push_back(16'h3000); exp_rd.push_back(16'h3001);
    exp_res.push_back('{16'h000E, 16'h5555, 16'h3002, 8'h47, 1'b0});
    launch(3'b110, 8'h42, 8'h01, 16'h0010, 16'h5555, 16'h3000);
    wait_done("cpir", 4, 1'b0, 16'h0);

    // CPI: 0x10-0x01 = 0x0F, H=1, n=0x0E -> Y=1, X=1; bc reaches 0 -> PV=0.
    mem[16'h4000] = 8'h01;
    exp_rd.push_back(16'h4000);
    exp_res.push_back('{16'h0000, 16'h1234, 16'h4001, 8'h3A, 1'b0});
    launch(3'b100, 8'h10, 8'h00, 16'h0001, 16'h1234, 16'h4000);
    wait_done("cpi", 2, 1'b0, 16'h0);
    check("cpi_alu_op1", 32'(alu_op1), 32'h01);

    // CPD at hl=0, bc=0: both wrap to 0xFFFF; 0x80-0x01=0x7F, H=1, n=0x7E, PV=1.
    mem[16'h0000] = 8'h01;
    exp_rd.push_back(16'h0000);
    exp_res.push_back('{16'hFFFF, 16'h0042, 16'hFFFF, 8'h3E, 1'b0});
    launch(3'b101, 8'h80, 8'h00, 16'h0000, 16'h0042, 16'h0000);
    wait_done("cpd_wrap", 2, 1'b0, 16'h0);

    // LDI at hl=de=0xFFFF wraps to 0; sum 0x08 -> X=1, Y=0; bc 0 -> 0xFFFF, PV=1.
    mem[16'hFFFF] = 8'h08;
    exp_rd.push_back(16'hFFFF);
    exp_wr.push_back('{16'hFFFF, 8'h08});
    exp_res.push_back('{16'hFFFF, 16'h0000, 16'h0000, 8'h0C, 1'b0});
    launch(3'b000, 8'h00, 8'h00, 16'h0000, 16'hFFFF, 16'hFFFF);
    wait_done("ldi_wrap", 3, 1'b0, 16'h0);

    // LDIR interrupted: irq raised in the 2nd WR; that iteration completes, then rewind.
    mem[16'h5000] = 8'h01; mem[16'h5001] = 8'h02;
    exp_rd.push_back(16'h5000); exp_rd.push_back(16'h5001);
    exp_wr.push_back('{16'h6000, 8'h01});
    exp_wr.push_back('{16'h6001, 8'h02});
    exp_res.push_back('{16'h0003, 16'h6002, 16'h5002, 8'h24, 1'b1});
    launch(3'b010, 8'h00, 8'h00, 16'h0005, 16'h6000, 16'h5000);
    wait_done("ldir_irq", 6, 1'b1, 16'h6001);

    // LDI with 4 wait cycles on the read: request held steady, no early write.
    mem[16'h7000] = 8'h03;
    exp_rd.push_back(16'h7000);
    exp_wr.push_back('{16'h7100, 8'h03});
    exp_res.push_back('{16'h0000, 16'h7101, 16'h7001, 8'h20, 1'b0});
    stall_total = stall_used + 4;
    launch(3'b000, 8'h00, 8'h00, 16'h0001, 16'h7100, 16'h7000);
    for (int i = 0; i < 4; i++) begin
      check("stall_rd", 32'(mem_if.mem_rd), 32'd1);
      check("stall_addr", 32'(mem_if.mem_addr), 32'h7000);
      check("stall_no_wr", 32'(mem_if.mem_wr), 32'd0);
      @(posedge clock); #1;
    end
    wait_done("ldi_stall", 3, 1'b0, 16'h0);

    // Reset asserted during WR: next cycle everything is back at reset values.
    mem[16'h7200] = 8'h44;
    exp_rd.push_back(16'h7200);
    launch(3'b000, 8'h00, 8'hFF, 16'h0009, 16'h7300, 16'h7200);
    for (int i = 0; i < 20 && !mem_if.mem_wr; i++) begin
      @(posedge clock); #1;
    end
    check("reset_reached_wr", 32'(mem_if.mem_wr), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_state("mid_reset");
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("post_reset_idle", 32'({busy, mem_if.mem_rd, mem_if.mem_wr}), 32'd0);

    check("rd_queue_left", 32'(exp_rd.size()), 32'd0);
    check("wr_queue_left", 32'(exp_wr.size()), 32'd0);
    check("res_queue_left", 32'(exp_res.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
